mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-port memory between instruction fetch (IF) and the load/store path (LS) of the RISC-V core. Round-robin on conflict, at most one read outstanding, read data routed back to the owner. Stall output holds fetch while it waits. Sits between the fetch stage, the data-memory access and the shared memory macro.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- ls_req  in  1  load/store request, held until granted
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_be  in  DATA_W/8  store byte enables
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid
- ls_rdata  out  DATA_W  load data
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rvalid  in  1  memory read data valid (any fixed or variable latency ≥1)
- mem_rdata  in  DATA_W  memory read data
- stall_o  out  1  if_req pending and not granted this cycle
- err_o  out  1  sticky: mem_rvalid with no read outstanding
- conflict_cnt  out  CNT_W  cycles with both requests pending, saturating

## Operation

- States: IDLE (no read outstanding), WAIT (read outstanding; owner register = IF or LS).
- IDLE: grant decision is combinational from the requests. Only one requesting: it is granted. Both requesting: grant the one not granted last (last_gnt register). Nothing requesting: no grant.
- Grant drives mem_req=1 with the granted address. For LS it also drives ls_we/ls_wdata/ls_be onto mem_we/mem_wdata/mem_be. IF grant drives mem_we=0 and mem_be all-ones.
- Granted store: completes in the grant cycle. State stays IDLE and no rvalid is returned.
- Granted read (IF, or LS with ls_we=0): owner ← requester, IDLE→WAIT.
- WAIT: no grants, mem_req=0. When mem_rvalid=1: route mem_rdata to the owner's rdata, pulse the owner's rvalid for that cycle, owner ← NONE, →IDLE.
- Same-cycle grant after response: not allowed. The first new grant comes the cycle after rvalid.
- rvalid/rdata are a combinational pass-through of mem_rvalid/mem_rdata, gated by owner. The non-owner rdata reads 0.
- mem_rvalid while in IDLE: ignored for routing. Sets err_o, which stays set until reset.
- conflict_cnt: +1 every cycle with if_req && ls_req, in either state. Saturates at all-ones.
- stall_o = if_req && !if_gnt.

## Timing

- Reset (rst=0 at clk edge) sets: state IDLE, owner NONE, last_gnt=IF (LS wins the first conflict), err_o=0, conflict_cnt=0.
- While rst=0, all of these are forced to 0: gnt, rvalid, mem_req, mem_we, stall_o.
- Grant latency: 0 cycles in IDLE.
- Read throughput: one read per (memory latency + 1) cycles. Stores: one per cycle.
- Reset asserted during WAIT: the outstanding read is abandoned. A mem_rvalid arriving after reset is released counts as IDLE rvalid and sets err_o. Integration must drain the memory before releasing reset.
- Requesters must hold req and its payload stable until gnt. Dropping req before gnt is legal; nothing is issued.
- last_gnt updates only on a conflict grant. A single-requester grant leaves it unchanged.

## Structure

- Shared package riscv_mem_pkg holds:
  - owner_e {OWN_NONE, OWN_IF, OWN_LS}
  - arb_state_e {ARB_IDLE, ARB_WAIT}
  - default ADDR_W/DATA_W constants
- One natural sub-module: arb_rr2. Two-way round-robin pick with the last_gnt register, enable on conflict.
- Everything else (FSM, owner register, counter, muxing) lives in mem_arbiter.

## Test plan

- Only if_req, addr 0x10; memory returns 0xDEADBEEF 2 cycles later -> if_gnt same cycle, WAIT, if_rvalid=1 with 0xDEADBEEF, ls_rvalid=0, back to IDLE next cycle.
- Both requesting from reset, ls_we=1 addr 0x40 -> ls_gnt first (store, stays IDLE); next cycle if_gnt; conflict_cnt=1; stall_o=1 for exactly one cycle.
- Back-to-back conflicting reads -> grants alternate LS, IF, LS; no grant while WAIT; stall_o high throughout IF's wait.
- mem_rvalid pulsed in IDLE -> err_o=1 and stays set; no rvalid to either side; cleared only by rst=0.
- rst=0 during WAIT, then released -> all outputs 0 during reset; IDLE after release; ls_req granted immediately.
- 2^CNT_W+5 consecutive conflict cycles -> conflict_cnt saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between instruction fetch and load/store.
// Remembers the last conflict winner so the other side takes the next conflict.
module arb_rr2
  import riscv_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_ls_i,
  output logic gnt_if_o,
  output logic gnt_ls_o
);

  owner_e last_gnt_q, last_gnt_d;
  logic   conflict;

  assign conflict = req_if_i && req_ls_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    gnt_if_o   = 1'b0;
    gnt_ls_o   = 1'b0;
    last_gnt_d = last_gnt_q;
    if (en_i) begin
      if (conflict) begin
        if (last_gnt_q == OWN_LS) begin
          gnt_if_o   = 1'b1;
          last_gnt_d = OWN_IF;
        end else begin
          gnt_ls_o   = 1'b1;
          last_gnt_d = OWN_LS;
        end
      end else begin
        // A lone requester wins without touching the round-robin pointer.
        gnt_if_o = req_if_i;
        gnt_ls_o = req_ls_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      last_gnt_q <= OWN_IF;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store with at most
// one read outstanding; read data is routed back to whichever side issued it.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    conflict_cnt
);

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle, arb_en, gnt_if, gnt_ls, rsp;

  assign idle   = (state_q == ARB_IDLE);
  // Gating with rst keeps every strobe low while reset is held.
  assign arb_en = rst && idle;

  arb_rr2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .req_if_i (if_req),
    .req_ls_i (ls_req),
    .gnt_if_o (gnt_if),
    .gnt_ls_o (gnt_ls)
  );

  assign if_gnt  = gnt_if;
  assign ls_gnt  = gnt_ls;
  assign stall_o = rst && if_req && !gnt_if;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt_if) begin
      mem_req  = 1'b1;
      mem_addr = if_addr;
      mem_be   = '1;
    end else if (gnt_ls) begin
      mem_req   = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_be    = ls_be;
    end
  end

  // Read return is a pass-through, steered by the registered owner.
  assign rsp       = rst && !idle && mem_rvalid;
  assign if_rvalid = rsp && (owner_q == OWN_IF);
  assign ls_rvalid = rsp && (owner_q == OWN_LS);
  assign if_rdata  = (owner_q == OWN_IF) ? mem_rdata : '0;
  assign ls_rdata  = (owner_q == OWN_LS) ? mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        // A response with nothing outstanding is a protocol error, never routed.
        if (mem_rvalid) err_d = 1'b1;
        if (gnt_if) begin
          state_d = ARB_WAIT;
          owner_d = OWN_IF;
        end else if (gnt_ls && !ls_we) begin
          state_d = ARB_WAIT;
          owner_d = OWN_LS;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    if (if_req && ls_req && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_o        = err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, hand-written corner
// sequences, a cycle model of the arbiter and a read-response scoreboard.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic [BE_W-1:0]   ls_be = '0;
  logic              ls_gnt, ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_o, err_o;
  logic [CNT_W-1:0]  conflict_cnt;

  logic              mdl_rvalid = 1'b0;
  logic [DATA_W-1:0] mdl_rdata = '0;
  logic              pulse_rvalid = 1'b0;
  logic [DATA_W-1:0] pulse_rdata = '0;

  assign mem_rvalid = mdl_rvalid | pulse_rvalid;
  assign mem_rdata  = mdl_rvalid ? mdl_rdata : pulse_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_o(stall_o), .err_o(err_o), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Scoreboard of reads granted but not yet answered.
  typedef struct packed {
    logic              is_ls;
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t sb_q[$];

  // Memory model: answers a read 'lat' cycles after it was issued.
  int                lat = 2;
  int                cd = 0;
  logic [DATA_W-1:0] rsp_data = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cd > 0) begin
        cd--;
        mdl_rvalid = (cd == 0);
        if (cd == 0) mdl_rdata = rsp_data;
      end else begin
        mdl_rvalid = 1'b0;
      end
    end
  end

  // Cycle model of the arbiter, compared with the DUT on every falling edge.
  bit               mon_en = 1'b0;
  logic             m_wait = 1'b0;
  logic             m_own_ls = 1'b0;
  logic             m_last_ls = 1'b0;
  logic             m_err = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic monitor_cycle();
    logic conf, e_gif, e_gls, e_req, e_we, e_stall, e_ifrv, e_lsrv;
    logic [ADDR_W-1:0] e_addr;
    logic [BE_W-1:0]   e_be;
    rsp_t r;
    conf  = if_req && ls_req;
    e_gif = 1'b0;
    e_gls = 1'b0;
    if (rst && !m_wait) begin
      if (conf) begin
        e_gls = !m_last_ls;
        e_gif = m_last_ls;
      end else begin
        e_gif = if_req;
        e_gls = ls_req;
      end
    end
    e_req   = e_gif | e_gls;
    e_we    = e_gls & ls_we;
    e_stall = rst & if_req & !e_gif;
    e_ifrv  = rst & m_wait & !m_own_ls & mem_rvalid;
    e_lsrv  = rst & m_wait & m_own_ls & mem_rvalid;
    check("cycle_ctrl",
          64'({if_gnt, ls_gnt, mem_req, mem_we, stall_o, if_rvalid, ls_rvalid, err_o}),
          64'({e_gif, e_gls, e_req, e_we, e_stall, e_ifrv, e_lsrv, m_err}));
    check("cycle_cnt", 64'(conflict_cnt), 64'(m_cnt));
    if (e_req) begin
      e_addr = e_gif ? if_addr : ls_addr;
      e_be   = e_gif ? {BE_W{1'b1}} : ls_be;
      check("mem_addr_be", 64'({mem_addr, mem_be}), 64'({e_addr, e_be}));
      if (e_we) check("mem_wdata", 64'(mem_wdata), 64'(ls_wdata));
    end
    if (if_rvalid || ls_rvalid) begin
      check("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check("sb_owner", 64'({if_rvalid, ls_rvalid}), 64'(r.is_ls ? 2'b01 : 2'b10));
        check("sb_data", 64'(r.is_ls ? ls_rdata : if_rdata), 64'(r.data));
        check("sb_other_rdata", 64'(r.is_ls ? if_rdata : ls_rdata), 64'(0));
      end
    end
    if (!rst) begin
      m_wait = 1'b0; m_own_ls = 1'b0; m_last_ls = 1'b0; m_err = 1'b0; m_cnt = '0;
      sb_q.delete();
      cd = 0;
    end else begin
      if (conf && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + CNT_W'(1);
      if (!m_wait) begin
        if (mem_rvalid) m_err = 1'b1;
        if (conf) m_last_ls = e_gls;
        if (e_gif) begin
          m_wait = 1'b1; m_own_ls = 1'b0;
          sb_q.push_back({1'b0, mem_data(if_addr)});
        end else if (e_gls && !ls_we) begin
          m_wait = 1'b1; m_own_ls = 1'b1;
          sb_q.push_back({1'b1, mem_data(ls_addr)});
        end
      end else if (mem_rvalid) begin
        m_wait = 1'b0;
      end
      if (mem_req && !mem_we) begin
        cd       = lat;
        rsp_data = mem_data(mem_addr);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) monitor_cycle();
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    pulse_rvalid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Waits (bounded) for a read response, then moves one cycle past it.
  task automatic wait_rsp(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = if_rvalid || ls_rvalid;
      step();
    end
    check(name, 64'(seen), 64'(1));
  endtask

  typedef struct {
    logic              if_req, ls_req, ls_we;
    logic [ADDR_W-1:0] if_addr, ls_addr;
    logic              exp_if_gnt, exp_ls_gnt, exp_read;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [2:0] seq;
    int         ngnt;

    // Round-robin starts with IF as last winner after reset.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,   1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h40,  1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h14,  32'h44,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h18,  32'h48,  1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h1C,  32'h4C,  1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h20,  32'h50,  1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h80,  1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h24,  32'h84,  1'b1, 1'b0, 1'b1};

    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step();
    rst = 1'b1;

    // Conflict out of reset: LS store first, then IF; one stall cycle.
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678; ls_be = 4'hF;
    @(negedge clk);
    check("s1_ls_first", 64'({if_gnt, ls_gnt, stall_o, mem_we}), 64'(4'b0111));
    step();
    ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
    check("s1_if_next", 64'({if_gnt, ls_gnt, stall_o}), 64'(3'b100));
    check("s1_cnt", 64'(conflict_cnt), 64'(1));
    step();
    if_req = 1'b0;
    wait_rsp("s1_if_rsp", 10);

    // Grant table, each vector applied from IDLE and drained.
    do_reset();
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      if_req = tbl[i].if_req; ls_req = tbl[i].ls_req; ls_we = tbl[i].ls_we;
      if_addr = tbl[i].if_addr; ls_addr = tbl[i].ls_addr;
      ls_wdata = 32'hA000_0000 | 32'(i); ls_be = 4'(4'h3 << (i % 2));
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i), 64'({if_gnt, ls_gnt}),
            64'({tbl[i].exp_if_gnt, tbl[i].exp_ls_gnt}));
      step();
      idle_inputs();
      if (tbl[i].exp_read) wait_rsp($sformatf("vec%0d_rsp", i), 10);
    end

    // Back-to-back conflicting reads alternate LS, IF, LS.
    do_reset();
    lat = 2;
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
    seq = 3'b000;
    ngnt = 0;
    for (int c = 0; c < 30 && ngnt < 3; c++) begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid)
        check("s3_no_gnt_on_rsp", 64'({if_gnt, ls_gnt}), 64'(0));
      if (if_gnt || ls_gnt) begin
        seq = {seq[1:0], ls_gnt};
        ngnt++;
      end
      if (ngnt < 3) step();
    end
    check("s3_grant_count", 64'(ngnt), 64'(3));
    check("s3_order", 64'(seq), 64'(3'b101));
    step();
    idle_inputs();
    wait_rsp("s3_last_rsp", 10);

    // Response with nothing outstanding: sticky error, nothing routed.
    pulse_rvalid = 1'b1; pulse_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("s4_no_rvalid", 64'({if_rvalid, ls_rvalid}), 64'(0));
    step();
    pulse_rvalid = 1'b0;
    @(negedge clk);
    check("s4_err_set", 64'(err_o), 64'(1));
    repeat (3) step();
    @(negedge clk);
    check("s4_err_sticky", 64'(err_o), 64'(1));
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("s4_err_cleared", 64'(err_o), 64'(0));
    step();
    rst = 1'b1;

    // Reset during WAIT abandons the read; LS is granted right after release.
    lat = 6;
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    check("s5_if_gnt", 64'(if_gnt), 64'(1));
    step();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h340; ls_wdata = 32'h5555_AAAA; ls_be = 4'hC;
    @(negedge clk);
    check("s5_wait_no_gnt", 64'({if_gnt, ls_gnt, mem_req, stall_o}), 64'(4'b0001));
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("s5_rst_outputs",
            64'({if_gnt, ls_gnt, mem_req, mem_we, stall_o, if_rvalid, ls_rvalid}), 64'(0));
      step();
    end
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    check("s5_ls_after_rst", 64'({ls_gnt, mem_req, mem_we}), 64'(3'b111));
    step();
    idle_inputs();
    repeat (8) step();
    @(negedge clk);
    check("s5_no_stale_err", 64'(err_o), 64'(0));
    step();

    // Long conflict run: counter saturates and never wraps.
    lat = 1;
    if_req = 1'b1; if_addr = 32'h400;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
    repeat ((1 << CNT_W) + 5) step();
    @(negedge clk);
    check("s6_saturated", 64'(conflict_cnt), 64'({CNT_W{1'b1}}));
    step();
    idle_inputs();
    repeat (4) step();
    @(negedge clk);
    check("s6_still_saturated", 64'(conflict_cnt), 64'({CNT_W{1'b1}}));
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
